// File: rtl/vbus_arbiter.sv
// Round-robin owner scheduler for the shared vertical bus driven by the last-row PEs.
// Grants fixed-length bursts paced by valid/ready, with one undriven turnaround cycle between owners.
module vbus_arbiter #(
    parameter int NUM_PE    = 8,
    parameter int BURST_LEN = 4,
    parameter int ID_W      = $clog2(NUM_PE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_PE-1:0] req,
    input  logic              bus_ready,
    output logic [NUM_PE-1:0] send_enable,
    output logic [ID_W-1:0]   grant_id,
    output logic              bus_valid,
    output logic              beat_last,
    output logic              busy
);
    localparam int               CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ID_W-1:0]  LAST_PE   = ID_W'(NUM_PE - 1);

    typedef enum logic [1:0] {IDLE, XFER, TURN} state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_nxt;
    logic [ID_W-1:0]  last_grant;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_id;
    logic [ID_W-1:0]  cand;

    assign beat_nxt = beat_cnt + 1'b1;

    // Search upward from the PE after the previous owner; the first hit in loop order wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_PE; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_PE);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            last_grant  <= LAST_PE;
            send_enable <= '0;
            grant_id    <= '0;
            bus_valid   <= 1'b0;
            beat_last   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (pick_valid) begin
                        state       <= XFER;
                        beat_cnt    <= '0;
                        send_enable <= NUM_PE'(1) << pick_id;
                        grant_id    <= pick_id;
                        bus_valid   <= 1'b1;
                        beat_last   <= (BURST_LEN == 1);
                        busy        <= 1'b1;
                    end else begin
                        state       <= IDLE;
                        send_enable <= '0;
                        grant_id    <= '0;
                        bus_valid   <= 1'b0;
                        beat_last   <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                XFER: begin
                    if (bus_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            // Release the bus for exactly one undriven cycle before the next owner.
                            state       <= TURN;
                            beat_cnt    <= '0;
                            last_grant  <= grant_id;
                            send_enable <= '0;
                            grant_id    <= '0;
                            bus_valid   <= 1'b0;
                            beat_last   <= 1'b0;
                        end else begin
                            beat_cnt  <= beat_nxt;
                            beat_last <= (beat_nxt == LAST_BEAT);
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    send_enable <= '0;
                    grant_id    <= '0;
                    bus_valid   <= 1'b0;
                    beat_last   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vbus_arbiter.sv
// Self-checking bench for vbus_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic scored against an owner/beat-count reference model.
module tb_vbus_arbiter;
    localparam int NUM_PE    = 8;
    localparam int BURST_LEN = 4;
    localparam int ID_W      = $clog2(NUM_PE);

    logic              clk;
    logic              reset;
    logic [NUM_PE-1:0] req;
    logic              bus_ready;
    logic [NUM_PE-1:0] send_enable;
    logic [ID_W-1:0]   grant_id;
    logic              bus_valid;
    logic              beat_last;
    logic              busy;

    vbus_arbiter #(
        .NUM_PE    (NUM_PE),
        .BURST_LEN (BURST_LEN),
        .ID_W      (ID_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .bus_ready   (bus_ready),
        .send_enable (send_enable),
        .grant_id    (grant_id),
        .bus_valid   (bus_valid),
        .beat_last   (beat_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic [NUM_PE-1:0] rq;
        logic              rdy;
        logic [NUM_PE-1:0] se;
        logic [ID_W-1:0]   gid;
        logic              valid;
        logic              last;
        logic              bsy;
    } vec_t;

    vec_t vecs [8];

    int n_checks;
    int n_fail;
    int hs_count;

    // Reference model: who owns the bus, how many beats it has delivered, and whether we are turning around.
    int m_owner;
    int m_done;
    int m_last;
    bit m_turn;

    int   order [$];
    int   gaps  [$];
    int   lens  [$];
    int   gap;
    int   len;
    logic pv;
    int   xfer_len;
    logic [NUM_PE-1:0] rq_rand;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_PE-1:0] r, input int last);
        for (int k = 1; k <= NUM_PE; k++) begin
            int c;
            logic [NUM_PE-1:0] sh;
            c  = (last + k) % NUM_PE;
            sh = r >> c;
            if (sh[0]) return c;
        end
        return -1;
    endfunction

    task automatic model_update(input logic r, input logic [NUM_PE-1:0] q, input logic rd);
        int w;
        if (r) begin
            m_owner = -1;
            m_done  = 0;
            m_turn  = 1'b0;
            m_last  = NUM_PE - 1;
        end else if (m_owner >= 0) begin
            if (rd) begin
                if (m_done == BURST_LEN - 1) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_done  = 0;
                    m_turn  = 1'b1;
                end else begin
                    m_done++;
                end
            end
        end else begin
            w      = rr_pick(q, m_last);
            m_turn = 1'b0;
            if (w >= 0) begin
                m_owner = w;
                m_done  = 0;
            end
        end
    endtask

    function automatic logic [31:0] model_pack();
        logic [NUM_PE-1:0] se;
        logic [ID_W-1:0]   gid;
        logic              v;
        logic              l;
        logic              b;
        se  = (m_owner >= 0) ? (NUM_PE'(1) << m_owner) : '0;
        gid = (m_owner >= 0) ? ID_W'(m_owner) : '0;
        v   = (m_owner >= 0);
        l   = (m_owner >= 0) && (m_done == BURST_LEN - 1);
        b   = (m_owner >= 0) || m_turn;
        return 32'({b, l, v, gid, se});
    endfunction

    function automatic logic [31:0] dut_pack();
        return 32'({busy, beat_last, bus_valid, grant_id, send_enable});
    endfunction

    task automatic compare_model(input string name);
        check(name, dut_pack(), model_pack());
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, then settle before sampling.
    task automatic step(input logic r, input logic [NUM_PE-1:0] q, input logic rd);
        reset     = r;
        req       = q;
        bus_ready = rd;
        if (!r && bus_valid === 1'b1 && rd) hs_count++;
        @(posedge clk);
        model_update(r, q, rd);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        hs_count  = 0;
        m_owner   = -1;
        m_done    = 0;
        m_last    = NUM_PE - 1;
        m_turn    = 1'b0;
        reset     = 1'b1;
        req       = '0;
        bus_ready = 1'b0;

        // Reset, single request from PE0, full burst, turnaround, back to idle.
        vecs[0] = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].rst, vecs[i].rq, vecs[i].rdy);
            check($sformatf("vec%0d_send_enable", i), 32'(send_enable), 32'(vecs[i].se));
            check($sformatf("vec%0d_grant_id", i), 32'(grant_id), 32'(vecs[i].gid));
            check($sformatf("vec%0d_bus_valid", i), 32'(bus_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_beat_last", i), 32'(beat_last), 32'(vecs[i].last));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
        end

        // All PEs requesting: grants rotate 0..7 then 0, 4-beat bursts separated by one dead cycle.
        step(1'b1, '0, 1'b0);
        gap = 0;
        len = 0;
        pv  = 1'b0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            step(1'b0, 8'hFF, 1'b1);
            compare_model("rr_all_cycle");
            if (bus_valid && !pv) begin
                order.push_back(int'(grant_id));
                gaps.push_back(gap);
                gap = 0;
                len = 1;
            end else if (bus_valid) begin
                len++;
            end else if (pv) begin
                lens.push_back(len);
                gap = 1;
            end else begin
                gap++;
            end
            pv = bus_valid;
        end
        check("rr_grant_count", 32'(order.size()), 32'd9);
        check("rr_len_count", 32'(lens.size()), 32'd9);
        for (int k = 0; k < 9; k++) begin
            if (k < order.size()) check($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k % NUM_PE));
            if (k > 0 && k < gaps.size()) check($sformatf("rr_gap%0d", k), 32'(gaps[k]), 32'd1);
            if (k < lens.size()) check($sformatf("rr_len%0d", k), 32'(lens[k]), 32'(BURST_LEN));
        end

        // Single PE with ready pattern 1,0,0,1,1,0,1: outputs hold on stalls, seven XFER cycles total.
        step(1'b1, '0, 1'b0);
        step(1'b0, 8'h04, 1'b0);
        check("stall_grant", 32'(send_enable), 32'h04);
        xfer_len = 1;
        for (int i = 0; i < 7; i++) begin
            logic [6:0] pat;
            pat = 7'b1011001;
            step(1'b0, 8'h00, pat[i]);
            compare_model("stall_cycle");
            if (i < 6) check("stall_hold_se", 32'(send_enable), 32'h04);
            if (bus_valid) xfer_len++;
        end
        check("stall_xfer_len", 32'(xfer_len), 32'd7);
        check("stall_turn_valid", 32'(bus_valid), 32'd0);
        check("stall_turn_busy", 32'(busy), 32'd1);

        // Wrap-around: PE6 owns, TURN sees 1000_0001, so PE7 wins, then PE0.
        step(1'b1, '0, 1'b0);
        step(1'b0, 8'h40, 1'b1);
        check("wrap_first_pe6", 32'(grant_id), 32'd6);
        for (int i = 0; i < BURST_LEN; i++) begin
            step(1'b0, 8'h81, 1'b1);
            compare_model("wrap_burst6");
        end
        check("wrap_turn_se", 32'(send_enable), 32'd0);
        step(1'b0, 8'h81, 1'b1);
        check("wrap_pe7", 32'(grant_id), 32'd7);
        for (int i = 0; i < BURST_LEN; i++) begin
            step(1'b0, 8'h81, 1'b1);
            compare_model("wrap_burst7");
        end
        step(1'b0, 8'h81, 1'b1);
        check("wrap_pe0", 32'(grant_id), 32'd0);
        check("wrap_pe0_se", 32'(send_enable), 32'h01);

        // Dropping req mid-burst does not shorten it; reset mid-burst restores PE0 priority.
        step(1'b1, '0, 1'b0);
        step(1'b0, 8'h08, 1'b1);
        check("drop_grant", 32'(grant_id), 32'd3);
        hs_count = 0;
        step(1'b0, 8'h08, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("drop_beats", 32'(hs_count), 32'(BURST_LEN));
        check("drop_turn_valid", 32'(bus_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h20, 1'b1);
        check("rst_mid_grant", 32'(grant_id), 32'd5);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        check("rst_mid_outputs", dut_pack(), 32'd0);
        step(1'b0, 8'hFF, 1'b1);
        check("rst_mid_next_pe0", 32'(grant_id), 32'd0);
        check("rst_mid_next_se", 32'(send_enable), 32'h01);

        // Randomized traffic with protocol invariants.
        step(1'b1, '0, 1'b0);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic r;
            logic rd;
            r       = ($urandom_range(0, 499) == 0);
            rd      = ($urandom_range(0, 3) != 0);
            rq_rand = ($urandom_range(0, 3) == 0) ? '0 : (NUM_PE'($urandom) & NUM_PE'($urandom));
            step(r, rq_rand, rd);
            compare_model("rand_outputs");
            check("rand_onehot", 32'($countones(send_enable) <= 1), 32'd1);
            check("rand_valid_eq_se", 32'(bus_valid), 32'(|send_enable));
            if (m_turn) check("rand_turn_se_zero", 32'(send_enable), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
